riscv_core_ldalign: RTL and testbench

- Load-data aligner/extender between the data cache read port and writeback.
- Accepts a load descriptor (byte offset, size, sign mode) and one or two XLEN-wide aligned memory beats.
- Merges beats for accesses crossing an XLEN boundary, shifts, then sign- or zero-extends.
- Returns a registered result over a valid/ready handshake.

---
 rtl/riscv_core_ldalign.sv | 159 +++++++++++++++
 tb/tb_riscv_core_ldalign.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_core_ldalign.sv
// Load-data aligner: merges one or two aligned cache beats, shifts the
// addressed bytes down and sign/zero-extends them for writeback.
module riscv_core_ldalign #(
  parameter int XLEN        = 64,
  parameter int MISALIGN_EN = 1,
  parameter int OFFW        = $clog2(XLEN/8)
) (
  input  logic            i_ldalign_clk,
  input  logic            i_ldalign_rst_n,
  input  logic            i_ldalign_req_valid,
  output logic            o_ldalign_req_ready,
  input  logic [OFFW-1:0] i_ldalign_req_offset,
  input  logic [1:0]      i_ldalign_req_size,
  input  logic            i_ldalign_req_su_extend,
  input  logic            i_ldalign_beat_valid,
  output logic            o_ldalign_beat_ready,
  input  logic [XLEN-1:0] i_ldalign_beat_data,
  input  logic            i_ldalign_beat_err,
  output logic            o_ldalign_split,
  output logic            o_ldalign_rsp_valid,
  input  logic            i_ldalign_rsp_ready,
  output logic [XLEN-1:0] o_ldalign_rsp_data,
  output logic            o_ldalign_rsp_err
);

  localparam int NB = XLEN / 8;

  typedef enum logic [1:0] {
    IDLE, BEAT0, BEAT1, RESP
  } state_t;

  state_t r_state, w_next;

  logic [OFFW-1:0] r_off;
  logic [1:0]      r_size;
  logic            r_su;
  logic            r_split;
  logic            r_err;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_rsp_data;
  logic            r_rsp_err;

  logic            w_req_hs;
  logic            w_beat_hs;
  logic            w_rsp_hs;
  logic            w_last;
  logic [3:0]      w_req_nb;
  logic [OFFW+4:0] w_req_end;
  logic            w_cross;
  logic            w_misal;
  logic            w_bad;

  logic [XLEN-1:0]   w_lo;
  logic [XLEN-1:0]   w_hi;
  logic [2*XLEN-1:0] w_cat;
  logic [XLEN-1:0]   w_shf;
  logic [7:0]        w_nbits;
  logic [XLEN-1:0]   w_mask;
  logic              w_sbit;
  logic [XLEN-1:0]   w_ext;
  logic              w_err;

  assign w_req_hs  = i_ldalign_req_valid && (r_state == IDLE);
  assign w_beat_hs = i_ldalign_beat_valid && o_ldalign_beat_ready;
  assign w_rsp_hs  = i_ldalign_rsp_ready && (r_state == RESP);

  assign w_req_nb  = 4'd1 << i_ldalign_req_size;
  assign w_req_end = (OFFW+5)'(i_ldalign_req_offset)
                   + (OFFW+5)'(w_req_nb);
  assign w_cross   = w_req_end > (OFFW+5)'(NB);
  assign w_misal   = |(i_ldalign_req_offset & OFFW'(w_req_nb - 4'd1));
  assign w_bad     = ((i_ldalign_req_size == 2'b11) && (XLEN == 32))
                  || ((MISALIGN_EN == 0) && w_misal);

  // Second beat supplies the upper half of the window; beat0 is held in r_lo.
  assign w_lo    = (r_state == BEAT1) ? r_lo : i_ldalign_beat_data;
  assign w_hi    = (r_state == BEAT1) ? i_ldalign_beat_data : '0;
  assign w_cat   = {w_hi, w_lo};
  assign w_shf   = XLEN'(w_cat >> {r_off, 3'b000});
  assign w_nbits = 8'd8 << r_size;
  assign w_mask  = ~({XLEN{1'b1}} << w_nbits);
  assign w_err   = r_err | i_ldalign_beat_err;
  assign w_last  = w_beat_hs && ((r_state == BEAT1) || !r_split);

  always_comb begin
    w_sbit = 1'b0;
    unique case (r_size)
      2'b00:   w_sbit = w_shf[7];
      2'b01:   w_sbit = w_shf[15];
      2'b10:   w_sbit = w_shf[31];
      default: w_sbit = 1'b0;
    endcase
  end

  assign w_ext = (w_shf & w_mask)
               | ({XLEN{w_sbit & ~r_su}} & ~w_mask);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (i_ldalign_req_valid) w_next = w_bad ? RESP : BEAT0;
      BEAT0: if (i_ldalign_beat_valid) w_next = r_split ? BEAT1 : RESP;
      BEAT1: if (i_ldalign_beat_valid) w_next = RESP;
      RESP:  if (i_ldalign_rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_ldalign_clk or negedge i_ldalign_rst_n) begin
    if (!i_ldalign_rst_n) r_state <= IDLE;
    else                  r_state <= w_next;
  end

  always_ff @(posedge i_ldalign_clk or negedge i_ldalign_rst_n) begin
    if (!i_ldalign_rst_n) begin
      r_off      <= '0;
      r_size     <= '0;
      r_su       <= 1'b0;
      r_split    <= 1'b0;
      r_err      <= 1'b0;
      r_lo       <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      if (w_req_hs) begin
        r_off   <= i_ldalign_req_offset;
        r_size  <= i_ldalign_req_size;
        r_su    <= i_ldalign_req_su_extend;
        r_split <= (MISALIGN_EN != 0) && w_cross && !w_bad;
        if (w_bad) begin
          r_rsp_err  <= 1'b1;
          r_rsp_data <= '0;
        end
      end
      if (w_beat_hs) begin
        r_err <= w_err;
        if (r_state == BEAT0) r_lo <= i_ldalign_beat_data;
      end
      if (w_last) begin
        r_rsp_err  <= w_err;
        r_rsp_data <= w_err ? '0 : w_ext;
      end
      if (w_rsp_hs) begin
        r_split    <= 1'b0;
        r_err      <= 1'b0;
        r_rsp_err  <= 1'b0;
        r_rsp_data <= '0;
      end
    end
  end

  assign o_ldalign_req_ready  = (r_state == IDLE);
  assign o_ldalign_beat_ready = (r_state == BEAT0) || (r_state == BEAT1);
  assign o_ldalign_split      = r_split;
  assign o_ldalign_rsp_valid  = (r_state == RESP);
  assign o_ldalign_rsp_data   = r_rsp_data;
  assign o_ldalign_rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_riscv_core_ldalign.sv
// Scoreboard bench for riscv_core_ldalign: 64b misaligned, 64b aligned-only
// and 32b instances, with a monitor popping expected responses.
module tb_riscv_core_ldalign;

  typedef struct packed {
    logic [63:0] d;
    logic        e;
  } exp_t;

  typedef struct {
    logic [2:0]  o;
    logic [1:0]  s;
    logic        u;
    logic [63:0] b0;
    logic [63:0] b1;
    logic        sp;
    logic [63:0] ed;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n[3];
  logic        req_valid[3];
  logic        req_ready[3];
  logic [2:0]  off[3];
  logic [1:0]  size[3];
  logic        su[3];
  logic        bvalid[3];
  logic        bready[3];
  logic [63:0] bdata[3];
  logic        berr[3];
  logic        split[3];
  logic        rvalid[3];
  logic        rready[3];
  logic        rerr[3];
  logic [63:0] rdata0, rdata1;
  logic [31:0] rdata2;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t q0[$], q1[$], q2[$];

  riscv_core_ldalign #(.XLEN(64), .MISALIGN_EN(1)) u0 (
    .i_ldalign_clk(clk), .i_ldalign_rst_n(rst_n[0]),
    .i_ldalign_req_valid(req_valid[0]), .o_ldalign_req_ready(req_ready[0]),
    .i_ldalign_req_offset(off[0]), .i_ldalign_req_size(size[0]),
    .i_ldalign_req_su_extend(su[0]),
    .i_ldalign_beat_valid(bvalid[0]), .o_ldalign_beat_ready(bready[0]),
    .i_ldalign_beat_data(bdata[0]), .i_ldalign_beat_err(berr[0]),
    .o_ldalign_split(split[0]), .o_ldalign_rsp_valid(rvalid[0]),
    .i_ldalign_rsp_ready(rready[0]), .o_ldalign_rsp_data(rdata0),
    .o_ldalign_rsp_err(rerr[0])
  );

  riscv_core_ldalign #(.XLEN(64), .MISALIGN_EN(0)) u1 (
    .i_ldalign_clk(clk), .i_ldalign_rst_n(rst_n[1]),
    .i_ldalign_req_valid(req_valid[1]), .o_ldalign_req_ready(req_ready[1]),
    .i_ldalign_req_offset(off[1]), .i_ldalign_req_size(size[1]),
    .i_ldalign_req_su_extend(su[1]),
    .i_ldalign_beat_valid(bvalid[1]), .o_ldalign_beat_ready(bready[1]),
    .i_ldalign_beat_data(bdata[1]), .i_ldalign_beat_err(berr[1]),
    .o_ldalign_split(split[1]), .o_ldalign_rsp_valid(rvalid[1]),
    .i_ldalign_rsp_ready(rready[1]), .o_ldalign_rsp_data(rdata1),
    .o_ldalign_rsp_err(rerr[1])
  );

  riscv_core_ldalign #(.XLEN(32), .MISALIGN_EN(1)) u2 (
    .i_ldalign_clk(clk), .i_ldalign_rst_n(rst_n[2]),
    .i_ldalign_req_valid(req_valid[2]), .o_ldalign_req_ready(req_ready[2]),
    .i_ldalign_req_offset(off[2][1:0]), .i_ldalign_req_size(size[2]),
    .i_ldalign_req_su_extend(su[2]),
    .i_ldalign_beat_valid(bvalid[2]), .o_ldalign_beat_ready(bready[2]),
    .i_ldalign_beat_data(bdata[2][31:0]), .i_ldalign_beat_err(berr[2]),
    .o_ldalign_split(split[2]), .o_ldalign_rsp_valid(rvalid[2]),
    .i_ldalign_rsp_ready(rready[2]), .o_ldalign_rsp_data(rdata2),
    .o_ldalign_rsp_err(rerr[2])
  );

  function automatic logic [63:0] rd(int d);
    if (d == 0) return rdata0;
    if (d == 1) return rdata1;
    return {32'b0, rdata2};
  endfunction

  function automatic int qsize(int d);
    if (d == 0) return q0.size();
    if (d == 1) return q1.size();
    return q2.size();
  endfunction

  function automatic exp_t qpop(int d);
    if (d == 0) return q0.pop_front();
    if (d == 1) return q1.pop_front();
    return q2.pop_front();
  endfunction

  task automatic push(int d, logic [63:0] ed, logic ee);
    exp_t x;
    x.d = ed;
    x.e = ee;
    if (d == 0) q0.push_back(x);
    else if (d == 1) q1.push_back(x);
    else q2.push_back(x);
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(string nm, int d);
    n_tests++;
    n_fail++;
    $display("FAIL %s timeout on dut%0d", nm, d);
  endtask

  task automatic do_req(int d, logic [2:0] o, logic [1:0] s, logic u);
    int n = 0;
    off[d] = o;
    size[d] = s;
    su[d] = u;
    req_valid[d] = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[d] && n < 50);
    if (!req_ready[d]) timeout("req", d);
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
  endtask

  task automatic do_beat(int d, logic [63:0] data, logic e);
    int n = 0;
    bdata[d] = data;
    berr[d] = e;
    bvalid[d] = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!bready[d] && n < 50);
    if (!bready[d]) timeout("beat", d);
    @(posedge clk);
    #1;
    bvalid[d] = 1'b0;
    berr[d] = 1'b0;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    logic [63:0] act;
    for (int d = 0; d < 3; d++) begin
      if (rst_n[d] && rvalid[d] && rready[d]) begin
        act = rd(d);
        if (qsize(d) == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rsp dut%0d: got data %h err %0b",
                   d, act, rerr[d]);
        end else begin
          e = qpop(d);
          chk($sformatf("rsp_data dut%0d", d), act, e.d);
          chk($sformatf("rsp_err dut%0d", d), {63'b0, rerr[d]}, {63'b0, e.e});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  vec_t v[9];

  initial begin
    v[0] = '{3'd3, 2'd0, 1'b0, 64'h0000_0000_8000_0000, 64'h0, 1'b0,
             64'hFFFF_FFFF_FFFF_FF80};
    v[1] = '{3'd6, 2'd1, 1'b1, 64'hBEEF_0000_0000_0000, 64'h0, 1'b0,
             64'h0000_0000_0000_BEEF};
    v[2] = '{3'd6, 2'd2, 1'b0, 64'h3412_0000_0000_0000,
             64'h0000_0000_0000_8765, 1'b1, 64'hFFFF_FFFF_8765_3412};
    v[3] = '{3'd0, 2'd3, 1'b0, 64'hFEDC_BA98_7654_3210, 64'h0, 1'b0,
             64'hFEDC_BA98_7654_3210};
    v[4] = '{3'd7, 2'd0, 1'b1, 64'hAB00_0000_0000_0000, 64'h0, 1'b0,
             64'h0000_0000_0000_00AB};
    v[5] = '{3'd7, 2'd1, 1'b0, 64'hCD00_0000_0000_0000,
             64'h0000_0000_0000_0080, 1'b1, 64'hFFFF_FFFF_FFFF_80CD};
    v[6] = '{3'd4, 2'd2, 1'b1, 64'h8765_4321_0000_0000, 64'h0, 1'b0,
             64'h0000_0000_8765_4321};
    v[7] = '{3'd1, 2'd3, 1'b0, 64'h8877_6655_4433_2211,
             64'h0000_0000_0000_00AA, 1'b1, 64'hAA88_7766_5544_3322};
    v[8] = '{3'd2, 2'd1, 1'b0, 64'h0000_0000_7FFF_0000, 64'h0, 1'b0,
             64'h0000_0000_0000_7FFF};

    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0;
      req_valid[d] = 1'b0;
      off[d] = '0;
      size[d] = '0;
      su[d] = 1'b0;
      bvalid[d] = 1'b0;
      bdata[d] = '0;
      berr[d] = 1'b0;
      rready[d] = 1'b1;
    end

    @(negedge clk);
    chk("reset req_ready", {63'b0, req_ready[0]}, 64'd1);
    chk("reset rsp_valid", {63'b0, rvalid[0]}, 64'd0);
    chk("reset beat_ready", {63'b0, bready[0]}, 64'd0);
    chk("reset split", {63'b0, split[0]}, 64'd0);
    chk("reset rsp_data", rdata0, 64'd0);
    chk("reset rsp_err", {63'b0, rerr[0]}, 64'd0);
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;

    // Beats presented while idle must not be taken.
    bvalid[0] = 1'b1;
    @(negedge clk);
    chk("idle beat_ready", {63'b0, bready[0]}, 64'd0);
    @(posedge clk);
    #1;
    bvalid[0] = 1'b0;

    for (int i = 0; i < 9; i++) begin
      push(0, v[i].ed, 1'b0);
      do_req(0, v[i].o, v[i].s, v[i].u);
      chk($sformatf("split v%0d", i), {63'b0, split[0]}, {63'b0, v[i].sp});
      do_beat(0, v[i].b0, 1'b0);
      if (v[i].sp) begin
        chk($sformatf("beat1 ready v%0d", i), {63'b0, bready[0]}, 64'd1);
        do_beat(0, v[i].b1, 1'b0);
      end
      @(negedge clk);
      chk($sformatf("latency v%0d", i), {63'b0, rvalid[0]}, 64'd1);
      @(posedge clk);
      #1;
    end

    // Split LD with a faulting first beat, response held off for 5 cycles.
    rready[0] = 1'b0;
    push(0, 64'd0, 1'b1);
    do_req(0, 3'd4, 2'd3, 1'b0);
    chk("err split", {63'b0, split[0]}, 64'd1);
    do_beat(0, 64'h1111_1111_1111_1111, 1'b1);
    chk("err beat1 ready", {63'b0, bready[0]}, 64'd1);
    do_beat(0, 64'h2222_2222_2222_2222, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("hold valid c%0d", i), {63'b0, rvalid[0]}, 64'd1);
      chk($sformatf("hold data c%0d", i), rdata0, 64'd0);
      chk($sformatf("hold err c%0d", i), {63'b0, rerr[0]}, 64'd1);
    end
    @(posedge clk);
    #1;
    rready[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post-hs req_ready", {63'b0, req_ready[0]}, 64'd1);
    chk("post-hs rsp_valid", {63'b0, rvalid[0]}, 64'd0);
    chk("post-hs split", {63'b0, split[0]}, 64'd0);
    @(posedge clk);
    #1;

    // Aligned-only instance: misaligned LH errors without touching beats.
    bvalid[1] = 1'b1;
    bdata[1] = 64'hDEAD_BEEF_DEAD_BEEF;
    push(1, 64'd0, 1'b1);
    do_req(1, 3'd1, 2'd1, 1'b0);
    @(negedge clk);
    chk("mis rsp 1cyc", {63'b0, rvalid[1]}, 64'd1);
    chk("mis beat_ready", {63'b0, bready[1]}, 64'd0);
    @(negedge clk);
    chk("mis idle beat_ready", {63'b0, bready[1]}, 64'd0);
    chk("mis idle req_ready", {63'b0, req_ready[1]}, 64'd1);
    @(posedge clk);
    #1;
    bvalid[1] = 1'b0;
    push(1, 64'h0000_0000_1234_5678, 1'b0);
    do_req(1, 3'd4, 2'd2, 1'b1);
    chk("aligned split", {63'b0, split[1]}, 64'd0);
    do_beat(1, 64'h1234_5678_0000_0000, 1'b0);
    @(negedge clk);
    chk("aligned latency", {63'b0, rvalid[1]}, 64'd1);
    @(posedge clk);
    #1;

    // 32-bit instance: LD is illegal.
    push(2, 64'd0, 1'b1);
    do_req(2, 3'd0, 2'd3, 1'b0);
    @(negedge clk);
    chk("x32 ld rsp 1cyc", {63'b0, rvalid[2]}, 64'd1);
    chk("x32 ld beat_ready", {63'b0, bready[2]}, 64'd0);
    @(posedge clk);
    #1;

    // Reset while waiting for the second beat drops the load.
    do_req(2, 3'd2, 2'd2, 1'b0);
    chk("x32 split", {63'b0, split[2]}, 64'd1);
    do_beat(2, 64'h0000_0000_1234_0000, 1'b0);
    chk("x32 in beat1", {63'b0, bready[2]}, 64'd1);
    rst_n[2] = 1'b0;
    @(negedge clk);
    chk("abort req_ready", {63'b0, req_ready[2]}, 64'd1);
    chk("abort rsp_valid", {63'b0, rvalid[2]}, 64'd0);
    chk("abort split", {63'b0, split[2]}, 64'd0);
    chk("abort beat_ready", {63'b0, bready[2]}, 64'd0);
    @(posedge clk);
    #1;
    rst_n[2] = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort no rsp", {63'b0, rvalid[2]}, 64'd0);
    @(posedge clk);
    #1;

    push(2, 64'h0000_0000_8000_0000, 1'b0);
    do_req(2, 3'd0, 2'd2, 1'b0);
    do_beat(2, 64'h0000_0000_8000_0000, 1'b0);
    push(2, 64'h0000_0000_FFFF_BEEF, 1'b0);
    do_req(2, 3'd2, 2'd1, 1'b0);
    do_beat(2, 64'h0000_0000_BEEF_0000, 1'b0);
    push(2, 64'h0000_0000_0000_55AA, 1'b0);
    do_req(2, 3'd3, 2'd1, 1'b0);
    chk("x32 lh split", {63'b0, split[2]}, 64'd1);
    do_beat(2, 64'h0000_0000_AA00_0000, 1'b0);
    do_beat(2, 64'h0000_0000_0000_0055, 1'b0);

    repeat (5) @(negedge clk);
    chk("queues drained", 64'(qsize(0) + qsize(1) + qsize(2)), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
